prbs4_checker: RTL
==================

Name: prbs4_checker

Overview:
- Receives the 4-bit pseudo-random word stream produced by the team's 4-bit LFSR generator and checks it against a locally predicted sequence.
- Self-synchronises to the incoming stream, then flags and counts mismatched words.
- Declares loss of lock after repeated consecutive errors.
- Sits directly downstream of the generator on the BIST/link-test path.

Parameters:
- LOCK_CNT, 3, consecutive correct predictions required to enter LOCKED (range 1..15)
- UNLOCK_CNT, 4, consecutive mismatches in LOCKED that force return to SEARCH (range 1..15)
- CNT_W, 16, width of the error and word counters

Ports:
- clk  input  1  clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- clear  input  1  synchronous clear of err_count and word_count; state is not affected
- data_valid  input  1  data_in carries a word this cycle
- data_in  input  4  received LFSR word
- locked  output  1  checker is synchronised to the stream
- error  output  1  one-cycle pulse: the previous valid word mismatched while LOCKED
- err_count  output  CNT_W  saturating count of mismatched words while LOCKED
- word_count  output  CNT_W  saturating count of valid words checked while LOCKED

Behaviour:
- Sequence definition: next(w) = {w[2:0], w[1]^w[3]}.
  - From seed 4'b1110 the period-6 cycle is 1110, 1100, 1001, 0011, 0111, 1111, 1110.
  - 4'b0000 is the lockup word.
- Reset (async, reset_n=0) sets:
  - state=SEARCH, pred=0, match_cnt=0, miss_cnt=0
  - locked=0, error=0, err_count=0, word_count=0
- All outputs are registered. Cycles with data_valid=0 change no state or counters, except that error returns to 0.
- SEARCH:
  - On a valid word != 0000: pred<=next(data_in), match_cnt<=0, go to VERIFY.
  - A valid 0000 is ignored; stay in SEARCH.
- VERIFY, on a valid word:
  - Match (data_in==pred): pred<=next(data_in), match_cnt++. If match_cnt+1==LOCK_CNT, go to LOCKED with locked<=1 on the same edge.
  - Mismatch, data_in != 0000: reseed with pred<=next(data_in), match_cnt<=0, stay in VERIFY.
  - Mismatch, data_in==0000: go to SEARCH.
  - No errors are counted in VERIFY.
- LOCKED (flywheel), on a valid word:
  - pred<=next(pred) regardless of data_in. The local predictor never reloads from data.
  - word_count++.
  - Match: miss_cnt<=0.
  - Mismatch: error<=1 for one cycle, err_count++, miss_cnt++.
  - If miss_cnt+1==UNLOCK_CNT: go to SEARCH with locked<=0 on that edge; miss_cnt<=0, match_cnt<=0.
- Latency: error and the counter updates become visible on the clock edge that samples the offending word, i.e. one cycle after data is presented.
- Counters saturate at all-ones and do not wrap.
- clear=1 zeroes both counters. If clear coincides with a counted word, the result is 0, because clear wins. clear has no effect on locked, state or pred.
- Reset mid-operation: immediate return to the reset values listed above, regardless of state.
- Back-to-back valid words every cycle must be supported.
- Gaps in data_valid do not break lock.

Test Plan:
- Lock-up: after reset, feed 1110, 1100, 1001, 0011 on consecutive valid cycles.
  - locked rises on the edge sampling 0011 (3 matches after the 1110 seed).
  - error stays 0; err_count=0.
- Single error: while locked, replace expected 0111 with 0101, then continue with the correct sequence (1111, 1110, ...).
  - One error pulse.
  - err_count=1; locked stays 1.
  - Following words match because of the flywheel, and miss_cnt clears.
- Loss of lock: while locked, feed four consecutive wrong words (e.g. 0000 x4).
  - error pulses 4 times; err_count=4.
  - locked drops on the 4th word's edge.
  - Re-lock occurs after a new valid seed plus 3 matches.
- Zero/garbage in search: feed 0000 x3, then 1001, 0000, then 0011, 0111, 1111, 1110.
  - Stays in SEARCH on the zeros.
  - VERIFY abandons back to SEARCH on the 0000 following the 1001.
  - Lock is reached at the 1110 (seed 0011, then 3 matches); err_count=0.
- Gapped valid and clear: while locked, feed the sequence with data_valid toggling 1/0, then assert clear together with a mismatched valid word.
  - Lock is held through the gaps.
  - After clear, err_count=0 and word_count=0; the error pulse still fires.
- Async reset mid-lock: assert reset_n=0 between clock edges while locked.
  - locked, error and both counters go to 0 immediately, without waiting for a clock edge.
  - After release, the checker re-locks on a fresh sequence.

Source files
------------

// File: rtl/prbs4_checker.sv
// prbs4_checker: checks a 4-bit LFSR word stream against a locally predicted
// sequence next(w) = {w[2:0], w[1]^w[3]}.
// It searches for a non-zero seed, confirms LOCK_CNT consecutive predictions,
// and then runs a flywheel predictor that counts words and mismatches.
// Ports:
//   clk, reset_n        rising-edge clock, async active-low reset
//   clear               sync clear of err_count/word_count (state untouched)
//   data_valid, data_in received word strobe and 4-bit word
//   locked              checker is synchronised to the stream
//   error               one-cycle pulse for a mismatched word while locked
//   err_count           saturating mismatch count while locked
//   word_count          saturating checked-word count while locked
module prbs4_checker #(
   parameter int unsigned LOCK_CNT   = 3,
   parameter int unsigned UNLOCK_CNT = 4,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clear,
   input  logic             data_valid,
   input  logic [3:0]       data_in,
   output logic             locked,
   output logic             error,
   output logic [CNT_W-1:0] err_count,
   output logic [CNT_W-1:0] word_count
);

   localparam int unsigned SEQ_W    = 4;
   localparam int unsigned RUN_W    = 4;
   localparam logic [RUN_W-1:0] LOCK_V   = RUN_W'(LOCK_CNT);
   localparam logic [RUN_W-1:0] UNLOCK_V = RUN_W'(UNLOCK_CNT);

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } state_t;

   state_t             state;
   logic [SEQ_W-1:0]   pred;
   logic [RUN_W-1:0]   match_cnt;
   logic [RUN_W-1:0]   miss_cnt;

   logic               pred_hit;
   logic               data_zero;
   logic               count_word;
   logic               count_err;

   // Next word of the generator sequence
   function automatic logic [SEQ_W-1:0] lfsr_next(input logic [SEQ_W-1:0] w);
      return {w[2:0], w[1] ^ w[3]};
   endfunction

   assign pred_hit   = (data_in == pred);
   assign data_zero  = (data_in == '0);
   assign count_word = data_valid && (state == LOCKED);
   assign count_err  = count_word && !pred_hit;

   // Synchronisation FSM with flywheel predictor
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= SEARCH;
         pred      <= '0;
         match_cnt <= '0;
         miss_cnt  <= '0;
         locked    <= 1'b0;
         error     <= 1'b0;
      end else begin
         error <= 1'b0;
         if (data_valid) begin
            case (state)
               SEARCH: begin
                  // The all-zero lockup word can never seed the predictor
                  if (!data_zero) begin
                     pred      <= lfsr_next(data_in);
                     match_cnt <= '0;
                     state     <= VERIFY;
                  end
               end
               VERIFY: begin
                  if (pred_hit) begin
                     pred      <= lfsr_next(data_in);
                     match_cnt <= match_cnt + RUN_W'(1);
                     if (match_cnt + RUN_W'(1) == LOCK_V) begin
                        state  <= LOCKED;
                        locked <= 1'b1;
                     end
                  end else if (!data_zero) begin
                     pred      <= lfsr_next(data_in);
                     match_cnt <= '0;
                  end else begin
                     state <= SEARCH;
                  end
               end
               LOCKED: begin
                  // Flywheel: prediction never reloads from received data
                  pred <= lfsr_next(pred);
                  if (pred_hit) begin
                     miss_cnt <= '0;
                  end else begin
                     error    <= 1'b1;
                     miss_cnt <= miss_cnt + RUN_W'(1);
                     if (miss_cnt + RUN_W'(1) == UNLOCK_V) begin
                        state     <= SEARCH;
                        locked    <= 1'b0;
                        miss_cnt  <= '0;
                        match_cnt <= '0;
                     end
                  end
               end
               default: begin
                  state  <= SEARCH;
                  locked <= 1'b0;
               end
            endcase
         end
      end
   end

   // Saturating counters; clear takes priority over a counted word
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         err_count  <= '0;
         word_count <= '0;
      end else if (clear) begin
         err_count  <= '0;
         word_count <= '0;
      end else begin
         if (count_word && (word_count != '1)) begin
            word_count <= word_count + CNT_W'(1);
         end
         if (count_err && (err_count != '1)) begin
            err_count <= err_count + CNT_W'(1);
         end
      end
   end

endmodule
